// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller (load-use, branch flush, dmem freeze, timeout trap)
// Ports:
//   clk, rst (async, active-high)
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_mem_read, ex_rd, ex_branch_taken    : EX-stage load flag, destination, taken branch
//   mem_req, dmem_ready                    : MEM-stage access in flight / completing
//   pc_write, ifid_write, idex_write, exmem_write : register enables (combinational)
//   ifid_flush, idex_flush                 : bubble injection (combinational)
//   state (RUN=00, FLUSH=01, ERR=11), mem_timeout (sticky until rst)
//   stall_cnt, freeze_cnt, branch_cnt      : saturating perf counters
// Macro HAZARD_PERF_EN builds the perf counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] branch_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01, ERR = 2'b11} state_t;
  localparam int FL_W = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
  state_t state_q;
  logic [FL_W-1:0] flush_left_q;
  logic [15:0] to_q;
  logic freeze, load_use, halt, stall;
  assign freeze = mem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // halt covers reset, the error trap and memory freeze: nothing captures, nothing flushes
  assign halt = rst | (state_q == ERR) | freeze;
  // load-use only stalls in RUN and yields to a taken branch, which squashes the consumer anyway
  assign stall = ~halt & ~ex_branch_taken & (state_q == RUN) & load_use;
  assign pc_write = ~halt & ~stall;
  assign ifid_write = ~halt & ~stall;
  assign idex_write = ~halt;
  assign exmem_write = ~halt;
  assign ifid_flush = ~halt & (ex_branch_taken | (state_q == FLUSH));
  assign idex_flush = ~halt & (ex_branch_taken | stall);
  assign state = state_q;
  assign mem_timeout = state_q == ERR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      flush_left_q <= '0;
      to_q <= '0;
    end else if (state_q != ERR) begin
      if (freeze) begin
        to_q <= to_q + 16'd1;
        if (to_q == TO_LAST) state_q <= ERR;
      end else begin
        to_q <= '0;
        if (ex_branch_taken) begin
          state_q <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
          flush_left_q <= FL_LOAD;
        end else if (state_q == FLUSH) begin
          if (flush_left_q == '0) state_q <= RUN;
          else flush_left_q <= flush_left_q - FL_W'(1);
        end
      end
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, freeze_q, branch_q;
  logic freeze_ev, branch_ev;
  assign freeze_ev = freeze & (state_q != ERR);
  assign branch_ev = ~halt & ex_branch_taken;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      freeze_q <= '0;
      branch_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(stall & ~&stall_q);
      freeze_q <= freeze_q + CNT_W'(freeze_ev & ~&freeze_q);
      branch_q <= branch_q + CNT_W'(branch_ev & ~&branch_q);
    end
  end
  assign stall_cnt = stall_q;
  assign freeze_cnt = freeze_q;
  assign branch_cnt = branch_q;
`else
  assign stall_cnt = '0;
  assign freeze_cnt = '0;
  assign branch_cnt = '0;
`endif
endmodule
